// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter feeding a single FIFO write port.
// A granted requester keeps the port for up to BURST consecutive writes.
module fifo_wr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [DW-1:0]      fifo_din,
    output logic [2:0]         owner,
    output logic               busy,
    output logic [15:0]        wr_cnt
);

    typedef enum logic {StIdle, StOwn} state_t;

    state_t      state_q;
    logic [2:0]  ptr_q;
    logic [2:0]  owner_q;
    logic [3:0]  cnt_q;
    logic [15:0] wr_cnt_q;

    logic [7:0] req_ext;
    logic       hold;
    logic [2:0] start;
    logic       found;
    logic [2:0] sel;
    logic       gvalid;
    logic [2:0] gidx;
    logic [3:0] idx;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (32'(i) == NREQ - 1) ? 3'd0 : i + 3'd1;
    endfunction

    always_comb begin
        req_ext = 8'(req);
        hold    = (state_q == StOwn) && req_ext[owner_q] && (cnt_q < 4'(BURST));
        // A releasing owner hands the scan start to the next index in the same cycle.
        start   = (state_q == StOwn) ? next_idx(owner_q) : ptr_q;
        found   = 1'b0;
        sel     = 3'd0;
        idx     = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, start} + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            if (!found && req_ext[idx[2:0]]) begin
                found = 1'b1;
                sel   = idx[2:0];
            end
        end
        gidx   = hold ? owner_q : sel;
        gvalid = rst && !fifo_full && (hold || found);
        gnt      = '0;
        fifo_din = '0;
        for (int k = 0; k < NREQ; k++) begin
            gnt[k] = gvalid && (3'(k) == gidx);
            if (gnt[k]) fifo_din = req_data[k*DW +: DW];
        end
        fifo_wr = |gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ptr_q    <= 3'd0;
            owner_q  <= 3'd0;
            cnt_q    <= 4'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            if (fifo_wr) wr_cnt_q <= wr_cnt_q + 16'd1;
            case (state_q)
                StIdle: begin
                    if (found && !fifo_full) begin
                        state_q <= StOwn;
                        owner_q <= sel;
                        cnt_q   <= 4'd1;
                    end
                end
                StOwn: begin
                    if (hold) begin
                        // Ownership is kept while the FIFO is full.
                        if (!fifo_full) cnt_q <= cnt_q + 4'd1;
                    end else begin
                        ptr_q <= next_idx(owner_q);
                        if (found && !fifo_full) begin
                            owner_q <= sel;
                            cnt_q   <= 4'd1;
                        end else begin
                            state_q <= StIdle;
                            cnt_q   <= 4'd0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign owner  = owner_q;
    assign busy   = (state_q == StOwn);
    assign wr_cnt = wr_cnt_q;

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 The block SHALL have parameter DW, default 8, data width matching FIFO din.
REQ-003 The block SHALL have parameter BURST, default 4, maximum consecutive grants per tenure (1..15).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port req  input  NREQ  per-requester write request, level.
REQ-007 The block SHALL have port req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW].
REQ-008 The block SHALL have port gnt  output  NREQ  one-hot-or-zero, gnt[i]=1 means req_data[i] written this cycle.
REQ-009 The block SHALL have port fifo_full  input  1  FIFO full flag.
REQ-010 The block SHALL have port fifo_wr  output  1  FIFO write strobe.
REQ-011 The block SHALL have port fifo_din  output  DW  FIFO write data.
REQ-012 The block SHALL have port owner  output  3  index of current tenure owner, valid when busy=1.
REQ-013 The block SHALL have port busy  output  1  1 when state is OWN.
REQ-014 The block SHALL have port wr_cnt  output  16  total accepted writes, wraps 0xFFFF->0x0000.

Function
REQ-015 The block SHALL implement states IDLE and OWN, with registers state, ptr (round-robin start index), owner, cnt (4-bit tenure count), and wr_cnt.
REQ-016 Arbitration SHALL select the first i with req[i]=1 scanning ptr, ptr+1, ... mod NREQ.
REQ-017 In IDLE, if any req and fifo_full=0, the block SHALL assert gnt for the selected index combinationally in the same cycle, then go to OWN with owner=index, cnt=1.
REQ-018 In IDLE with fifo_full=1 or no req, gnt SHALL be 0 and state SHALL remain IDLE.
REQ-019 In OWN, if req[owner]=1, cnt<BURST and fifo_full=0, the block SHALL grant owner and increment cnt.
REQ-020 In OWN, if req[owner]=1, cnt<BURST and fifo_full=1, gnt SHALL be 0, with state, owner and cnt held (ownership kept while full).
REQ-021 In OWN, if req[owner]=0 or cnt==BURST, the tenure SHALL release: ptr<=owner+1 mod NREQ, and that same cycle SHALL be arbitrated per REQ-016/017/018 using owner+1 as start index.
REQ-022 On a release with a single requester equal to the old owner, the old owner SHALL be re-granted (wrap-around) and start a new tenure with cnt=1.
REQ-023 fifo_wr SHALL equal |gnt, and fifo_wr SHALL never be 1 while fifo_full=1.
REQ-024 fifo_din SHALL equal the req_data slice of the granted index, and SHALL be 0 when fifo_wr=0.
REQ-025 wr_cnt SHALL increment by 1 on each rising edge where fifo_wr=1.
REQ-026 Grant latency from req rise SHALL be 0 cycles when the FIFO is not full and the bus is free.
REQ-027 No requester SHALL wait more than (NREQ-1)*BURST grants while continuously requesting.

Reset
REQ-028 While rst=0, the block SHALL force state=IDLE, ptr=0, owner=0, cnt=0, wr_cnt=0, busy=0, gnt=0, fifo_wr=0, and fifo_din=0, asynchronously.
REQ-029 Reset asserted mid-tenure SHALL abort the tenure immediately with no write.
REQ-030 After rst rises, the first arbitration SHALL start at index 0.

Verification
REQ-031 Scenario: NREQ=4, BURST=4, req=4'b1111 held, full=0, 16 cycles -> gnt order is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3, and wr_cnt=16.
REQ-032 Scenario: req=4'b0100 held, BURST=4 -> gnt[2] every cycle across tenure boundaries, and busy stays 1.
REQ-033 Scenario: owner=1 with cnt=2, fifo_full=1 for 3 cycles -> gnt=0 and fifo_wr=0 for those cycles, then owner 1 receives 2 more grants before release.
REQ-034 Scenario: req=4'b1010 with data 0xA1 at index 1 and 0xA3 at index 3, and req[1] dropped after 1 grant -> next cycle gnt[3]=1 and fifo_din=0xA3.
REQ-035 Scenario: rst=0 asserted asynchronously mid-burst between clock edges -> gnt=0 and fifo_wr=0 immediately; after release, req=4'b1000 gives gnt[3], and req=4'b1111 gives gnt[0] first.
REQ-036 Scenario: preload wr_cnt to 0xFFFE via 0xFFFE writes, then 3 more writes -> wr_cnt reads 0xFFFF, 0x0000, 0x0001.
